lsu_multi: RTL and testbench

Parametrised load/store unit for the multicycle RISC-V core. It sits between the datapath's Address/WriteData/MemMode signals and a variable-latency data memory. Each access passes through a request/acknowledge handshake with a timeout. The unit generates byte enables, performs lane steering and sign/zero extension, and flags misaligned or timed-out accesses. It generalises the fixed single-cycle, 32-bit memory path to XLEN 32 or 64 and to wait-stated memories.

---
 rtl/lsu_multi.sv | 193 +++++++++++++++++++
 tb/tb_lsu_multi.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_multi.sv
// Load/store unit for the multicycle core: request handshake, byte enables, lane steering, load extension, timeout.
// Latency: accept edge N -> resp_valid during cycle N+2 with an immediate ack, +1 per memory wait cycle; errors respond at N+1.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack or TIMEOUT cycles, whichever comes first.
//
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_we/req_mode/req_unsigned/req_addr/req_wdata : datapath request
//   resp_valid/resp_rdata/resp_err/busy                                 : completion and status
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata/mem_ack          : data memory side
module lsu_multi #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_mode,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic                resp_err,
   output logic                busy,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_ack
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic                we_q, we_d;
   logic [1:0]          mode_q, mode_d;
   logic                uns_q, uns_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   logic                req_bad;
   logic [OFFW-1:0]     off_q;
   logic [XLEN-1:0]     rd_shift;
   logic [XLEN-1:0]     ld_ext;
   logic                ld_fill;
   logic [XLEN-1:0]     wd_rep;
   logic [NB-1:0]       be_dec;
   logic                in_access;

   assign off_q     = addr_q[OFFW-1:0];
   assign in_access = (state_q == S_ACCESS);

   // Alignment is checked against the access size; doubles need 8-byte alignment
   // and do not exist at all on a 32-bit datapath.
   always_comb begin
      req_bad = 1'b0;
      case (req_mode)
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = |req_addr[1:0];
         2'b11:   req_bad = (XLEN == 32) || (|req_addr[2:0]);
         default: req_bad = 1'b0;
      endcase
   end

   // Load extraction: bring the addressed lane down to bit 0, then fill the
   // upper bits with the sign (or zero) of the selected width.
   assign rd_shift = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_fill = 1'b0;
      case (mode_q)
         2'b00:   ld_fill = ~uns_q & rd_shift[7];
         2'b01:   ld_fill = ~uns_q & rd_shift[15];
         2'b10:   ld_fill = ~uns_q & rd_shift[31];
         default: ld_fill = 1'b0;
      endcase
      ld_ext = '0;
      for (int i = 0; i < XLEN; i++) begin
         ld_ext[i] = (i < (8 << mode_q)) ? rd_shift[i] : ld_fill;
      end
   end

   // Store data is replicated so the memory can pick any lane via mem_be.
   always_comb begin
      wd_rep = '0;
      be_dec = '0;
      for (int i = 0; i < NB; i++) begin
         wd_rep[8*i +: 8] = wdata_q[8*(i & ((1 << mode_q) - 1)) +: 8];
         be_dec[i] = (mode_q == 2'b11) ||
                     ((i >= int'(off_q)) && (i < int'(off_q) + (1 << mode_q)));
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      we_d    = we_q;
      mode_d  = mode_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               mode_d  = req_mode;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               timer_d = '0;
               rdata_d = '0;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // An ack in the expiry cycle still counts as a successful access.
            if (mem_ack) begin
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : ld_ext;
               state_d = S_RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         we_q    <= 1'b0;
         mode_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         we_q    <= we_d;
         mode_q  <= mode_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory-side outputs are forced to zero outside ACCESS so stale request
   // fields never leak onto the bus.
   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = (state_q == S_RESP) & err_q;
   assign resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
   assign mem_req    = in_access;
   assign mem_we     = in_access & we_q;
   assign mem_addr   = in_access ? (addr_q & ~ADDR_W'(NB - 1)) : '0;
   assign mem_wdata  = in_access ? wd_rep : '0;
   assign mem_be     = in_access ? be_dec : '0;

endmodule

// File: tb/tb_lsu_multi.sv
module tb_lsu_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        v32, v64;
   logic        req_we;
   logic [1:0]  req_mode;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   logic        r32_ready, r32_rv, r32_err, r32_busy, m32_req, m32_we;
   logic [31:0] r32_rdata, m32_addr, m32_wdata;
   logic [3:0]  m32_be;
   logic        r64_ready, r64_rv, r64_err, r64_busy, m64_req, m64_we;
   logic [63:0] r64_rdata, m64_wdata;
   logic [31:0] m64_addr;
   logic [7:0]  m64_be;

   logic        sel;   // 0: 32-bit unit (TIMEOUT 4), 1: 64-bit unit (TIMEOUT 6)
   logic        o_ready, o_rv, o_err, o_busy, o_mreq, o_mwe;
   logic [63:0] o_rdata, o_mwd;
   logic [31:0] o_maddr;
   logic [7:0]  o_mbe;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_multi #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
      .clk(clk), .reset(reset), .req_valid(v32), .req_ready(r32_ready),
      .req_we(req_we), .req_mode(req_mode), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .resp_valid(r32_rv), .resp_rdata(r32_rdata), .resp_err(r32_err), .busy(r32_busy),
      .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr), .mem_wdata(m32_wdata),
      .mem_be(m32_be), .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack));

   lsu_multi #(.XLEN(64), .ADDR_W(32), .TIMEOUT(6)) u64 (
      .clk(clk), .reset(reset), .req_valid(v64), .req_ready(r64_ready),
      .req_we(req_we), .req_mode(req_mode), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(r64_rv), .resp_rdata(r64_rdata), .resp_err(r64_err), .busy(r64_busy),
      .mem_req(m64_req), .mem_we(m64_we), .mem_addr(m64_addr), .mem_wdata(m64_wdata),
      .mem_be(m64_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

   always_comb begin
      if (sel) begin
         o_ready = r64_ready; o_rv = r64_rv; o_err = r64_err; o_busy = r64_busy;
         o_mreq = m64_req; o_mwe = m64_we; o_rdata = r64_rdata; o_mwd = m64_wdata;
         o_maddr = m64_addr; o_mbe = m64_be;
      end else begin
         o_ready = r32_ready; o_rv = r32_rv; o_err = r32_err; o_busy = r32_busy;
         o_mreq = m32_req; o_mwe = m32_we; o_rdata = {32'd0, r32_rdata};
         o_mwd = {32'd0, m32_wdata}; o_maddr = m32_addr; o_mbe = {4'd0, m32_be};
      end
   end

   // ---------------- reference model (access-size arithmetic) ----------------
   function automatic int nbytes();
      return sel ? 8 : 4;
   endfunction

   function automatic logic model_bad(input logic [1:0] mode, input logic [31:0] addr);
      int sz = 1 << mode;
      return (mode == 2'd3 && !sel) || ((addr % sz) != 0);
   endfunction

   function automatic logic [7:0] model_be(input logic [1:0] mode, input logic [31:0] addr);
      logic [7:0] be = '0;
      int off = int'(addr[2:0]) % nbytes();
      int sz = 1 << mode;
      for (int i = 0; i < nbytes(); i++) be[i] = (mode == 2'd3) || (i >= off && i < off + sz);
      return be;
   endfunction

   function automatic logic [63:0] model_wd(input logic [1:0] mode, input logic [63:0] wd);
      logic [63:0] r = '0;
      int sz = 1 << mode;
      for (int i = 0; i < nbytes(); i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] model_ld(input logic [1:0] mode, input logic uns,
                                            input logic [31:0] addr, input logic [63:0] rd);
      logic [63:0] r, mask;
      logic neg;
      int off = int'(addr[2:0]) % nbytes();
      int sz = 1 << mode;
      r = sel ? rd : (rd & 64'hFFFF_FFFF);
      r = r >> (8 * off);
      if (sz < 8) begin
         mask = (64'd1 << (8 * sz)) - 64'd1;
         neg = r[8*sz-1];
         r = r & mask;
         if (!uns && neg) r = r | ~mask;
      end
      if (!sel) r = r & 64'hFFFF_FFFF;
      return r;
   endfunction

   // One access: drives the request, plays a memory that acks after 'waits'
   // wait cycles, and checks bus fields, latency and response against the model.
   task automatic run_access(input logic we, input logic [1:0] mode, input logic uns,
                             input logic [31:0] addr, input logic [63:0] wd,
                             input logic [63:0] rd, input int waits);
      int to, c, exp_c;
      logic is_bad, e_err;
      logic [63:0] e_rd, e_wd;
      logic [7:0] e_be;
      logic [31:0] e_addr;
      to = sel ? 6 : 4;
      is_bad = model_bad(mode, addr);
      e_be = model_be(mode, addr);
      e_wd = model_wd(mode, wd);
      e_addr = addr & ~32'(nbytes() - 1);
      checks++;
      if (o_ready !== 1'b1) begin
         failures++; $display("FAIL ready_idle got=%b exp=1", o_ready);
      end
      req_we = we; req_mode = mode; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      if (sel) v64 = 1'b1; else v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0; v64 = 1'b0;
      if (is_bad) begin
         checks++;
         if ({o_rv, o_err, o_rdata, o_mreq} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
            failures++;
            $display("FAIL err_resp addr=%h mode=%0d got rv/err/rdata/mreq=%b/%b/%h/%b exp=1/1/0/0",
                     addr, mode, o_rv, o_err, o_rdata, o_mreq);
         end
      end else begin
         c = 0;
         mem_rdata = rd;
         while (1) begin
            checks++;
            if ({o_mreq, o_busy, o_ready} !== 3'b110) begin
               failures++; $display("FAIL access_ctl cyc=%0d got=%b exp=110", c, {o_mreq, o_busy, o_ready});
            end
            checks++;
            if ({o_mwe, o_maddr, o_mwd, o_mbe} !== {we, e_addr, e_wd, e_be}) begin
               failures++;
               $display("FAIL mem_bus cyc=%0d got we=%b a=%h wd=%h be=%h exp we=%b a=%h wd=%h be=%h",
                        c, o_mwe, o_maddr, o_mwd, o_mbe, we, e_addr, e_wd, e_be);
            end
            mem_ack = (c == waits);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            c++;
            if (o_rv === 1'b1) break;
            if (c > to + 1) begin
               checks++; failures++;
               $display("FAIL resp_missing got=none after %0d cycles exp=resp_valid", c);
               break;
            end
         end
         exp_c = (waits + 1 < to) ? waits + 1 : to;
         e_err = (waits >= to);
         e_rd = (we || e_err) ? 64'd0 : model_ld(mode, uns, addr, rd);
         checks++;
         if (c !== exp_c) begin
            failures++; $display("FAIL latency got=%0d exp=%0d", c, exp_c);
         end
         checks++;
         if ({o_err, o_rdata} !== {e_err, e_rd}) begin
            failures++;
            $display("FAIL resp addr=%h mode=%0d we=%b got err=%b rdata=%h exp err=%b rdata=%h",
                     addr, mode, we, o_err, o_rdata, e_err, e_rd);
         end
      end
      @(posedge clk); #1;
      checks++;
      if ({o_rv, o_ready} !== 2'b01) begin
         failures++; $display("FAIL resp_pulse got rv/ready=%b exp=01", {o_rv, o_ready});
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; v32 = 1'b0; v64 = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      req_we = 1'b0; req_mode = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({o_ready, o_rv, o_err, o_busy, o_mreq, o_mwe, o_rdata, o_mwd, o_maddr, o_mbe} !==
             {1'b1, 5'd0, 64'd0, 64'd0, 32'd0, 8'd0}) begin
            failures++; $display("FAIL reset_state unit=%0d got ready=%b busy=%b mreq=%b exp ready=1 rest=0",
                                 s, o_ready, o_busy, o_mreq);
         end
      end
      reset = 1'b1;
      // A stray ack while idle must not start anything.
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if ({o_ready, o_rv, o_busy} !== 3'b100) begin
            failures++; $display("FAIL idle_ack unit=%0d got=%b exp=100", s, {o_ready, o_rv, o_busy});
         end
      end
   endtask

   task automatic test_directed();
      sel = 1'b0;
      run_access(1'b0, 2'b10, 1'b0, 32'h100, 64'd0, 64'h8000_1234, 0);
      run_access(1'b0, 2'b00, 1'b0, 32'h103, 64'd0, 64'h80AB_CDEF, 0);
      run_access(1'b0, 2'b00, 1'b1, 32'h103, 64'd0, 64'h80AB_CDEF, 1);
      run_access(1'b1, 2'b01, 1'b0, 32'h102, 64'hABCD, 64'd0, 3);
      run_access(1'b0, 2'b10, 1'b0, 32'h101, 64'd0, 64'h1, 0);
      run_access(1'b0, 2'b11, 1'b0, 32'h108, 64'd0, 64'h1, 0);
      sel = 1'b1;
      run_access(1'b0, 2'b11, 1'b1, 32'h108, 64'd0, 64'hF123_4567_89AB_CDEF, 0);
      run_access(1'b1, 2'b11, 1'b0, 32'h108, 64'h0102_0304_0506_0708, 64'd0, 2);
      run_access(1'b0, 2'b10, 1'b0, 32'h10C, 64'd0, 64'h9000_0001_0000_0002, 0);
      run_access(1'b0, 2'b10, 1'b1, 32'h10C, 64'd0, 64'h9000_0001_0000_0002, 0);
      run_access(1'b0, 2'b11, 1'b0, 32'h10C, 64'd0, 64'h1, 0);
   endtask

   task automatic test_timeout();
      sel = 1'b0;
      run_access(1'b0, 2'b10, 1'b0, 32'h200, 64'd0, 64'h5555_AAAA, 99);
      run_access(1'b0, 2'b10, 1'b0, 32'h200, 64'd0, 64'h5555_AAAA, 3);
      run_access(1'b1, 2'b00, 1'b0, 32'h201, 64'h7E, 64'd0, 4);
      sel = 1'b1;
      run_access(1'b0, 2'b01, 1'b0, 32'h20E, 64'd0, 64'h8001_0000_0000_0000, 99);
      run_access(1'b0, 2'b01, 1'b0, 32'h20E, 64'd0, 64'h8001_0000_0000_0000, 5);
   endtask

   task automatic test_reset_mid_access();
      sel = 1'b0;
      req_we = 1'b0; req_mode = 2'b10; req_unsigned = 1'b0; req_addr = 32'h300; req_wdata = '0;
      v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      checks++;
      if (o_mreq !== 1'b1) begin
         failures++; $display("FAIL abort_setup got mreq=%b exp=1", o_mreq);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({o_mreq, o_busy, o_ready, o_rv} !== 4'b0010) begin
         failures++; $display("FAIL abort_state got mreq/busy/ready/rv=%b exp=0010",
                              {o_mreq, o_busy, o_ready, o_rv});
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({o_rv, o_ready} !== 2'b01) begin
            failures++; $display("FAIL abort_no_resp cyc=%0d got rv/ready=%b exp=01", i, {o_rv, o_ready});
         end
      end
      run_access(1'b0, 2'b10, 1'b0, 32'h300, 64'd0, 64'hCAFE_F00D, 1);
   endtask

   task automatic test_random();
      logic [1:0] mode;
      logic [31:0] addr;
      int to, waits;
      for (int n = 0; n < 160; n++) begin
         sel = $urandom_range(0, 1) == 1;
         to = sel ? 6 : 4;
         mode = 2'($urandom_range(0, 3));
         addr = $urandom & 32'hFFFF_FFF8;
         addr = addr | 32'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << mode) - 1);
         waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, to + 1) : $urandom_range(0, 2);
         run_access($urandom_range(0, 1) == 1, mode, $urandom_range(0, 1) == 1, addr,
                    {$urandom, $urandom}, {$urandom, $urandom}, waits);
      end
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_directed();
      test_timeout();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=no_finish exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
